forward_hazard_unit: RTL and testbench

- Parametrised successor to the single-port forwarding mux.
- Provides NUM_RD_PORTS forwarding muxes with priority: load completion > mem stage > wb stage > register file.
- Adds a per-register load scoreboard for variable-latency loads. It raises a load-use stall while a source register has an outstanding load.
- Sits between decode/register-read and the EX stage of the pipelined core.

---
 rtl/forward_hazard_unit.sv | 134 +++++++++++++
 tb/tb_forward_hazard_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/forward_hazard_unit.sv
// Multi-port operand forwarding with a load scoreboard for variable-latency loads.
// Optional FWD_ZERO_REG_EN hardwires register 0 to zero and makes loads to it no-ops.
module forward_hazard_port #(
  parameter int DBITS = 32,
  parameter int RIW   = 4
) (
  input  logic [DBITS-1:0]  reg_data,
  input  logic [RIW-1:0]    r,
  input  logic [2**RIW-1:0] pending,
  input  logic [DBITS-1:0]  mem_data,
  input  logic [RIW-1:0]    mem_rd,
  input  logic              mem_wen,
  input  logic [DBITS-1:0]  wb_data,
  input  logic [RIW-1:0]    wb_rd,
  input  logic              wb_wen,
  input  logic              ld_done,
  input  logic [RIW-1:0]    ld_done_rd,
  input  logic [DBITS-1:0]  ld_done_data,
  output logic [DBITS-1:0]  data,
  output logic              haz
);
  logic byp;

  always_comb begin
    byp = ld_done && (ld_done_rd == r);
    if (byp)                        data = ld_done_data;
    else if (mem_wen && mem_rd == r) data = mem_data;
    else if (wb_wen && wb_rd == r)   data = wb_data;
    else                            data = reg_data;
    // a load returning this cycle is bypassed rather than stalled
    haz = pending[r] && !byp;
`ifdef FWD_ZERO_REG_EN
    if (r == '0) begin
      data = '0;
      haz  = 1'b0;
    end
`endif
  end
endmodule

module forward_hazard_unit #(
  parameter int DBITS               = 32,
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int NUM_RD_PORTS        = 2,
  parameter int MAX_OUTSTANDING     = 4,
  parameter int STALL_CNT_BITS      = 16
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_RD_PORTS*DBITS-1:0]           regData,
  input  logic [NUM_RD_PORTS*REG_INDEX_BIT_WIDTH-1:0] regno,
  input  logic [DBITS-1:0]                        memData,
  input  logic [REG_INDEX_BIT_WIDTH-1:0]          memRd,
  input  logic                                    memWrtEn,
  input  logic [DBITS-1:0]                        wbData,
  input  logic [REG_INDEX_BIT_WIDTH-1:0]          wbRd,
  input  logic                                    wbWrtEn,
  input  logic                                    ldIssue,
  input  logic [REG_INDEX_BIT_WIDTH-1:0]          ldRd,
  input  logic                                    ldDone,
  input  logic [REG_INDEX_BIT_WIDTH-1:0]          ldDoneRd,
  input  logic [DBITS-1:0]                        ldDoneData,
  output logic [NUM_RD_PORTS*DBITS-1:0]           out,
  output logic                                    stall,
  output logic                                    ldFull,
  output logic                                    ldOvf,
  output logic [STALL_CNT_BITS-1:0]               stallCount
);
  localparam int RIW   = REG_INDEX_BIT_WIDTH;
  localparam int NREGS = 2**RIW;
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);

  logic [NREGS-1:0]        pending, pend_nxt;
  logic [OW-1:0]           outstanding, out_nxt;
  logic [NUM_RD_PORTS-1:0] haz;
  logic                    iss_req, iss_acc, done_vld;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    forward_hazard_port #(.DBITS(DBITS), .RIW(RIW)) u_port (
      .reg_data    (regData[p*DBITS +: DBITS]),
      .r           (regno[p*RIW +: RIW]),
      .pending     (pending),
      .mem_data    (memData),
      .mem_rd      (memRd),
      .mem_wen     (memWrtEn),
      .wb_data     (wbData),
      .wb_rd       (wbRd),
      .wb_wen      (wbWrtEn),
      .ld_done     (ldDone),
      .ld_done_rd  (ldDoneRd),
      .ld_done_data(ldDoneData),
      .data        (out[p*DBITS +: DBITS]),
      .haz         (haz[p])
    );
  end

  assign stall = |haz;

`ifdef FWD_ZERO_REG_EN
  assign iss_req = ldIssue && (ldRd != '0);
`else
  assign iss_req = ldIssue;
`endif
  assign iss_acc  = iss_req && !ldFull;
  assign done_vld = ldDone && pending[ldDoneRd];

  // clear before set so a same-register issue keeps the entry pending
  always_comb begin
    pend_nxt = pending;
    if (done_vld) pend_nxt[ldDoneRd] = 1'b0;
    if (iss_acc)  pend_nxt[ldRd]     = 1'b1;
    case ({iss_acc, done_vld})
      2'b10:   out_nxt = outstanding + OW'(1);
      2'b01:   out_nxt = outstanding - OW'(1);
      default: out_nxt = outstanding;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending     <= '0;
      outstanding <= '0;
      ldFull      <= 1'b0;
      ldOvf       <= 1'b0;
      stallCount  <= '0;
    end else begin
      pending     <= pend_nxt;
      outstanding <= out_nxt;
      ldFull      <= (out_nxt == OW'(MAX_OUTSTANDING));
      if (iss_req && ldFull) ldOvf <= 1'b1;
      if (stall && stallCount != '1) stallCount <= stallCount + 1'b1;
    end
  end
endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit: forwarding priority, load scoreboard, capacity, reset.
module tb_forward_hazard_unit;
  localparam int D = 32, R = 4, P = 2, SB = 4;

  logic clk = 1'b0, reset = 1'b1;
  logic [P*D-1:0] regData;
  logic [P*R-1:0] regno;
  logic [D-1:0] memData, wbData, ldDoneData;
  logic [R-1:0] memRd, wbRd, ldRd, ldDoneRd;
  logic memWrtEn, wbWrtEn, ldIssue, ldDone;
  logic [P*D-1:0] out;
  logic stall, ldFull, ldOvf;
  logic [SB-1:0] stallCount;
  logic [D-1:0] out0, out1;
  int checks = 0, errors = 0;

  assign out0 = out[D-1:0];
  assign out1 = out[2*D-1:D];

  forward_hazard_unit #(.DBITS(D), .REG_INDEX_BIT_WIDTH(R), .NUM_RD_PORTS(P),
                        .MAX_OUTSTANDING(4), .STALL_CNT_BITS(SB)) dut (
    .clk(clk), .reset(reset), .regData(regData), .regno(regno),
    .memData(memData), .memRd(memRd), .memWrtEn(memWrtEn),
    .wbData(wbData), .wbRd(wbRd), .wbWrtEn(wbWrtEn),
    .ldIssue(ldIssue), .ldRd(ldRd), .ldDone(ldDone), .ldDoneRd(ldDoneRd),
    .ldDoneData(ldDoneData), .out(out), .stall(stall), .ldFull(ldFull),
    .ldOvf(ldOvf), .stallCount(stallCount));

  always #5 clk = ~clk;

  // inputs change on negedge; the following posedge commits them
  task automatic issue(input logic [R-1:0] rd);
    @(negedge clk); ldIssue = 1'b1; ldRd = rd; ldDone = 1'b0;
  endtask

  task automatic done(input logic [R-1:0] rd);
    @(negedge clk); ldIssue = 1'b0; ldDone = 1'b1; ldDoneRd = rd;
  endtask

  task automatic idle();
    @(negedge clk); ldIssue = 1'b0; ldDone = 1'b0;
  endtask

  task automatic test_reset();
    regData = {32'hA1, 32'hA0}; regno = {4'd1, 4'd0};
    memData = '0; wbData = '0; ldDoneData = '0;
    memRd = '0; wbRd = '0; ldRd = '0; ldDoneRd = '0;
    memWrtEn = 0; wbWrtEn = 0; ldIssue = 0; ldDone = 0;
    #1;
    checks++; if (out !== {32'hA1, 32'hA0}) begin $display("FAIL reset_out got %h exp %h", out, {32'hA1, 32'hA0}); errors++; end
    checks++; if (stall !== 1'b0) begin $display("FAIL reset_stall got %b exp 0", stall); errors++; end
    checks++; if (stallCount !== '0) begin $display("FAIL reset_cnt got %0d exp 0", stallCount); errors++; end
    checks++; if ({ldFull, ldOvf} !== 2'b00) begin $display("FAIL reset_flags got %b exp 00", {ldFull, ldOvf}); errors++; end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_priority();
    @(negedge clk);
    regno = {4'd1, 4'd3}; memRd = 3; wbRd = 3; memData = 32'hB; wbData = 32'hC;
    memWrtEn = 1; wbWrtEn = 1; #1;
    checks++; if (out0 !== 32'hB) begin $display("FAIL prio_mem got %h exp b", out0); errors++; end
    checks++; if (out1 !== 32'hA1) begin $display("FAIL prio_p1_rf got %h exp a1", out1); errors++; end
    memWrtEn = 0; #1;
    checks++; if (out0 !== 32'hC) begin $display("FAIL prio_wb got %h exp c", out0); errors++; end
    memWrtEn = 1; ldDone = 1; ldDoneRd = 3; ldDoneData = 32'hD; #1;
    checks++; if (out0 !== 32'hD) begin $display("FAIL prio_ld got %h exp d", out0); errors++; end
    memWrtEn = 0; wbWrtEn = 0; ldDone = 0;
  endtask

  task automatic test_load_use();
    regno = {4'd7, 4'd3};
    issue(5);
    idle(); regno = {4'd5, 4'd3}; #1;
    checks++; if (stall !== 1'b1) begin $display("FAIL lu_stall1 got %b exp 1", stall); errors++; end
    idle(); #1;
    checks++; if (stall !== 1'b1) begin $display("FAIL lu_stall2 got %b exp 1", stall); errors++; end
    idle(); #1;
    checks++; if (stall !== 1'b1) begin $display("FAIL lu_stall3 got %b exp 1", stall); errors++; end
    done(5); ldDoneData = 32'h55; #1;
    checks++; if (stall !== 1'b0) begin $display("FAIL lu_bypass_stall got %b exp 0", stall); errors++; end
    checks++; if (out1 !== 32'h55) begin $display("FAIL lu_bypass_out got %h exp 55", out1); errors++; end
    idle(); #1;
    checks++; if (stall !== 1'b0) begin $display("FAIL lu_cleared got %b exp 0", stall); errors++; end
    checks++; if (stallCount !== 4'd3) begin $display("FAIL lu_cnt got %0d exp 3", stallCount); errors++; end
    regno = {4'd15, 4'd15};
  endtask

  task automatic test_capacity();
    issue(1); issue(2); issue(3);
    idle(); #1;
    checks++; if (ldFull !== 1'b0) begin $display("FAIL cap_notfull got %b exp 0", ldFull); errors++; end
    issue(4);
    idle(); #1;
    checks++; if (ldFull !== 1'b1) begin $display("FAIL cap_full got %b exp 1", ldFull); errors++; end
    checks++; if (ldOvf !== 1'b0) begin $display("FAIL cap_noovf got %b exp 0", ldOvf); errors++; end
    issue(6);
    idle(); regno = {4'd15, 4'd6}; #1;
    checks++; if (ldOvf !== 1'b1) begin $display("FAIL cap_ovf got %b exp 1", ldOvf); errors++; end
    checks++; if (stall !== 1'b0) begin $display("FAIL cap_drop_pend6 got %b exp 0", stall); errors++; end
    checks++; if (ldFull !== 1'b1) begin $display("FAIL cap_full_hold got %b exp 1", ldFull); errors++; end
    regno = {4'd15, 4'd15};
    done(1);
    idle(); #1;
    checks++; if (ldFull !== 1'b0) begin $display("FAIL cap_done_unfull got %b exp 0", ldFull); errors++; end
    // issue and done together: count stays at 3
    @(negedge clk); ldIssue = 1; ldRd = 7; ldDone = 1; ldDoneRd = 2;
    idle(); regno = {4'd15, 4'd7}; #1;
    checks++; if (ldFull !== 1'b0) begin $display("FAIL cap_both_cnt got %b exp 0", ldFull); errors++; end
    checks++; if (stall !== 1'b1) begin $display("FAIL cap_pend7 got %b exp 1", stall); errors++; end
    regno = {4'd15, 4'd15};
    issue(8);
    idle(); #1;
    checks++; if (ldFull !== 1'b1) begin $display("FAIL cap_refull got %b exp 1", ldFull); errors++; end
    done(3); done(4); done(7); done(8);
    idle(); regno = {4'd8, 4'd4}; #1;
    checks++; if ({ldFull, stall} !== 2'b00) begin $display("FAIL cap_drain got %b exp 00", {ldFull, stall}); errors++; end
    regno = {4'd15, 4'd15};
  endtask

  task automatic test_simultaneous();
    issue(2);
    @(negedge clk); ldIssue = 1; ldRd = 2; ldDone = 1; ldDoneRd = 2;
    idle(); regno = {4'd15, 4'd2}; #1;
    checks++; if (stall !== 1'b1) begin $display("FAIL sim_pend2 got %b exp 1", stall); errors++; end
    regno = {4'd15, 4'd15};
    issue(10); issue(11);
    idle(); #1;
    checks++; if (ldFull !== 1'b0) begin $display("FAIL sim_cnt3 got %b exp 0", ldFull); errors++; end
    issue(12);
    idle(); #1;
    checks++; if (ldFull !== 1'b1) begin $display("FAIL sim_cnt4 got %b exp 1", ldFull); errors++; end
    done(9);
    idle(); regno = {4'd15, 4'd9}; #1;
    checks++; if ({ldFull, stall} !== 2'b10) begin $display("FAIL sim_ignore9 got %b exp 10", {ldFull, stall}); errors++; end
    done(12);
    idle(); #1;
    checks++; if (ldFull !== 1'b0) begin $display("FAIL sim_done12 got %b exp 0", ldFull); errors++; end
  endtask

  task automatic test_saturation();
    regno = {4'd15, 4'd2};
    repeat (20) idle();
    #1;
    checks++; if (stallCount !== 4'hF) begin $display("FAIL sat_cnt got %0d exp 15", stallCount); errors++; end
  endtask

  task automatic test_async_reset();
    regno = {4'd10, 4'd2};
    @(posedge clk); #2; reset = 1'b1; #1;
    checks++; if (stall !== 1'b0) begin $display("FAIL ar_stall got %b exp 0", stall); errors++; end
    checks++; if ({ldFull, ldOvf} !== 2'b00) begin $display("FAIL ar_flags got %b exp 00", {ldFull, ldOvf}); errors++; end
    checks++; if (stallCount !== '0) begin $display("FAIL ar_cnt got %0d exp 0", stallCount); errors++; end
    #1; reset = 1'b0;
    idle(); regno = {4'd11, 4'd10}; #1;
    checks++; if (stall !== 1'b0) begin $display("FAIL ar_post_stall got %b exp 0", stall); errors++; end
    regno = {4'd15, 4'd15};
    done(2); issue(1); issue(3); issue(4);
    idle(); #1;
    checks++; if (ldFull !== 1'b0) begin $display("FAIL ar_cnt_restart got %b exp 0", ldFull); errors++; end
    issue(5);
    idle(); #1;
    checks++; if (ldFull !== 1'b1) begin $display("FAIL ar_cnt_full got %b exp 1", ldFull); errors++; end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_load_use();
    test_capacity();
    test_simultaneous();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
